// File: rtl/hazard_scoreboard_ctrl.sv
// hazard_scoreboard_ctrl: RAW hazard / branch flush controller for the
// 5-stage 18-bit core. A per-register busy scoreboard tracks in-flight
// writes; fetch/decode are held and execute gets a bubble while a decode
// source is busy. A stall watchdog forces a one-cycle RECOVER that wipes
// the scoreboard and latches a sticky deadlock flag.
// Optional build macro: HAZARD_WB_BYPASS_EN (write-first register file,
// a source matching the retiring writeback is not a hazard).

// One scoreboard entry: busy flag for one architectural register.
module hsb_entry (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  input  logic wipe,
  output logic busy
);
  // Set beats clear so a newer writer issuing while the older one retires
  // keeps the register marked in flight; wipe (RECOVER) beats both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      busy <= 1'b0;
    else if (wipe) busy <= 1'b0;
    else if (set)  busy <= 1'b1;
    else if (clr)  busy <= 1'b0;
  end
endmodule

module hazard_scoreboard_ctrl #(
  parameter int NREGS     = 32,
  parameter int MAX_STALL = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_d,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rd_d,
  input  logic             uses_rs1_d,
  input  logic             uses_rs2_d,
  input  logic             regwrite_d,
  input  logic             regwrite_w,
  input  logic [4:0]       rd_w,
  input  logic             branch_taken_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic             deadlock,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {S_RUN, S_STALL, S_RECOVER} state_t;

  state_t           state, state_nxt;
  logic [7:0]       stall_len, stall_len_nxt;
  logic [NREGS-1:0] busy;
  logic [31:0]      busy_ext;
  logic             byp1, byp2;
  logic             hazard, issue, in_recover;

  assign in_recover = (state == S_RECOVER);

  // Zero-extend the scoreboard so any 5-bit address indexes safely.
  always_comb begin
    busy_ext              = '0;
    busy_ext[NREGS-1:0]   = busy;
  end

`ifdef HAZARD_WB_BYPASS_EN
  // Write-first register file: the retiring value is visible to decode now.
  assign byp1 = regwrite_w && (rd_w == rs1_d);
  assign byp2 = regwrite_w && (rd_w == rs2_d);
`else
  // Register file writes at the edge: a same-cycle writeback match still stalls.
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign hazard = valid_d &&
                  ((uses_rs1_d && busy_ext[rs1_d] && !byp1) ||
                   (uses_rs2_d && busy_ext[rs2_d] && !byp2));

  // Only an instruction that actually advances out of decode claims rd.
  assign issue = valid_d && regwrite_d && !hazard && !branch_taken_e && !in_recover;

  // Scoreboard entries, one per tracked register.
  for (genvar i = 0; i < NREGS; i++) begin : g_ent
    hsb_entry u_ent (
      .clk  (clk),
      .rst  (rst),
      .set  (issue && (rd_d == 5'(i))),
      .clr  (regwrite_w && (rd_w == 5'(i))),
      .wipe (in_recover),
      .busy (busy[i])
    );
  end

  // Pipeline control: branch flush beats hazard stall; all quiet in reset/RECOVER.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (rst && !in_recover) begin
      if (branch_taken_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (hazard) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  // Watchdog FSM next state; stall_len counts consecutive stalled cycles,
  // including the RUN cycle that first stalled.
  always_comb begin
    state_nxt     = state;
    stall_len_nxt = stall_len;
    case (state)
      S_RUN: begin
        if (hazard && !branch_taken_e) begin
          state_nxt     = S_STALL;
          stall_len_nxt = 8'd1;
        end
      end
      S_STALL: begin
        if (branch_taken_e || !hazard) begin
          state_nxt     = S_RUN;
          stall_len_nxt = 8'd0;
        end else if (stall_len == 8'(MAX_STALL - 1)) begin
          state_nxt     = S_RECOVER;
          stall_len_nxt = 8'd0;
        end else begin
          stall_len_nxt = stall_len + 8'd1;
        end
      end
      S_RECOVER: begin
        state_nxt     = S_RUN;
        stall_len_nxt = 8'd0;
      end
      default: begin
        state_nxt     = S_RUN;
        stall_len_nxt = 8'd0;
      end
    endcase
  end

  // FSM state and stall-length registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_RUN;
      stall_len <= 8'd0;
    end else begin
      state     <= state_nxt;
      stall_len <= stall_len_nxt;
    end
  end

  // Sticky deadlock flag, raised as the FSM enters RECOVER.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        deadlock <= 1'b0;
    else if (state_nxt == S_RECOVER) deadlock <= 1'b1;
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_d && (stall_cnt != {CNT_W{1'b1}}))        stall_cnt <= stall_cnt + 1'b1;
      if (branch_taken_e && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Self-checking bench for hazard_scoreboard_ctrl. A reference model keeps
// the scoreboard as a bit array plus a consecutive-stall count, and checks
// the default DUT and a CNT_W=4 copy (for counter saturation).
module tb_hazard_scoreboard_ctrl;
  localparam int MAXS = 64;

  logic clk = 1'b0;
  logic rst;
  logic valid_d, uses_rs1_d, uses_rs2_d, regwrite_d, regwrite_w, branch_taken_e;
  logic [4:0] rs1_d, rs2_d, rd_d, rd_w;
  logic stall_f, stall_d, flush_d, flush_e, deadlock;
  logic [15:0] stall_cnt, flush_cnt;
  logic s_stall_f, s_stall_d, s_flush_d, s_flush_e, s_deadlock;
  logic [3:0] s_stall_cnt, s_flush_cnt;
  logic [4:0] obs;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  bit [31:0]   m_busy;
  int          m_consec;
  bit          m_recover, m_deadlock;
  logic [15:0] m_scnt, m_fcnt;
  logic [3:0]  m_scnt_s, m_fcnt_s;

  always #5 clk = ~clk;

  assign obs = {stall_f, stall_d, flush_d, flush_e, deadlock};

  hazard_scoreboard_ctrl #(.NREGS(32), .MAX_STALL(MAXS), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d), .regwrite_d(regwrite_d),
    .regwrite_w(regwrite_w), .rd_w(rd_w), .branch_taken_e(branch_taken_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .deadlock(deadlock), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  hazard_scoreboard_ctrl #(.NREGS(32), .MAX_STALL(MAXS), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d), .regwrite_d(regwrite_d),
    .regwrite_w(regwrite_w), .rd_w(rd_w), .branch_taken_e(branch_taken_e),
    .stall_f(s_stall_f), .stall_d(s_stall_d), .flush_d(s_flush_d), .flush_e(s_flush_e),
    .deadlock(s_deadlock), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

  function automatic bit m_hazard();
    bit b1, b2;
    b1 = 1'b0;
    b2 = 1'b0;
`ifdef HAZARD_WB_BYPASS_EN
    b1 = regwrite_w && (rd_w == rs1_d);
    b2 = regwrite_w && (rd_w == rs2_d);
`endif
    return valid_d && ((uses_rs1_d && m_busy[rs1_d] && !b1) ||
                       (uses_rs2_d && m_busy[rs2_d] && !b2));
  endfunction

  // expected {stall_f, stall_d, flush_d, flush_e, deadlock}
  function automatic logic [4:0] m_ctrl();
    if (!rst)           return 5'b00000;
    if (m_recover)      return {4'b0000, m_deadlock};
    if (branch_taken_e) return {4'b0011, m_deadlock};
    if (m_hazard())     return {4'b1101, m_deadlock};
    return {4'b0000, m_deadlock};
  endfunction

  task automatic m_clear();
    m_busy = '0; m_consec = 0; m_recover = 0; m_deadlock = 0;
    m_scnt = '0; m_fcnt = '0; m_scnt_s = '0; m_fcnt_s = '0;
  endtask

  // advance the model over one clock edge using the current inputs
  task automatic tick();
    bit haz;
    if (!rst) m_clear();
    else if (m_recover) begin
      m_busy = '0; m_recover = 0; m_consec = 0;
      if (branch_taken_e) begin
        if (m_fcnt != 16'hFFFF) m_fcnt++;
        if (m_fcnt_s != 4'hF) m_fcnt_s++;
      end
    end else begin
      haz = m_hazard();
      if (haz && !branch_taken_e) begin
        if (m_scnt != 16'hFFFF) m_scnt++;
        if (m_scnt_s != 4'hF) m_scnt_s++;
        m_consec++;
        if (m_consec == MAXS) begin m_recover = 1; m_deadlock = 1; m_consec = 0; end
      end else m_consec = 0;
      if (branch_taken_e) begin
        if (m_fcnt != 16'hFFFF) m_fcnt++;
        if (m_fcnt_s != 4'hF) m_fcnt_s++;
      end
      if (regwrite_w) m_busy[rd_w] = 1'b0;
      if (valid_d && regwrite_d && !haz && !branch_taken_e) m_busy[rd_d] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_d = 0; uses_rs1_d = 0; uses_rs2_d = 0; regwrite_d = 0; regwrite_w = 0;
    branch_taken_e = 0; rs1_d = 0; rs2_d = 0; rd_d = 0; rd_w = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    #1;
    tick();
    tick();
    rst = 1;
  endtask

  task automatic issue(input logic [4:0] r);
    idle();
    valid_d = 1; regwrite_d = 1; rd_d = r;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst = 0; valid_d = 1; uses_rs1_d = 1; branch_taken_e = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_chk++;
      if (obs !== 5'b00000 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got ctrl=%b scnt=%0d fcnt=%0d, want ctrl=00000 scnt=0 fcnt=0",
                 obs, stall_cnt, flush_cnt);
      end
      tick();
    end
    rst = 1;
    idle();
    valid_d = 1; uses_rs1_d = 1; uses_rs2_d = 1;
    for (int r = 0; r < 32; r++) begin
      rs1_d = 5'(r); rs2_d = 5'(31 - r);
      #1;
      n_chk++;
      if (stall_d !== 1'b0 || flush_e !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_busy_clear r%0d: got stall_d=%b flush_e=%b, want 0 0", r, stall_d, flush_e);
      end
    end
    idle();
  endtask

  task automatic test_raw_stall();
    logic [4:0] exp_c;
    do_reset();
    issue(5'd5);
    idle(); valid_d = 1; uses_rs1_d = 1; rs1_d = 5'd5;
    #1;
    n_chk++;
    if (obs !== 5'b11010) begin n_fail++; $display("FAIL raw_stall: got %b want 11010", obs); end
    tick();
    regwrite_w = 1; rd_w = 5'd5;
`ifdef HAZARD_WB_BYPASS_EN
    exp_c = 5'b00000;
`else
    exp_c = 5'b11010;
`endif
    #1;
    n_chk++;
    if (obs !== exp_c || obs !== m_ctrl()) begin
      n_fail++; $display("FAIL raw_retire_cycle: got %b want %b", obs, exp_c);
    end
    tick();
    regwrite_w = 0;
    #1;
    n_chk++;
    if (obs !== 5'b00000) begin n_fail++; $display("FAIL raw_after_retire: got %b want 00000", obs); end
    n_chk++;
`ifdef HAZARD_WB_BYPASS_EN
    if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL raw_stall_cnt: got %0d want 1", stall_cnt); end
`else
    if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL raw_stall_cnt: got %0d want 2", stall_cnt); end
`endif
    tick();
    idle();
  endtask

  task automatic test_branch_priority();
    do_reset();
    issue(5'd9);
    idle(); valid_d = 1; uses_rs1_d = 1; rs1_d = 5'd9; regwrite_d = 1; rd_d = 5'd12;
    branch_taken_e = 1;
    #1;
    n_chk++;
    if (obs !== 5'b00110) begin n_fail++; $display("FAIL branch_priority: got %b want 00110", obs); end
    tick();
    branch_taken_e = 0; regwrite_d = 0; rs1_d = 5'd12;
    #1;
    n_chk++;
    if (obs !== 5'b00000) begin n_fail++; $display("FAIL branch_no_issue: got %b want 00000", obs); end
    rs1_d = 5'd9;
    #1;
    n_chk++;
    if (obs !== 5'b11010) begin n_fail++; $display("FAIL branch_r9_still_busy: got %b want 11010", obs); end
    n_chk++;
    if (flush_cnt !== 16'd1 || flush_cnt !== m_fcnt) begin
      n_fail++; $display("FAIL branch_flush_cnt: got %0d want 1", flush_cnt);
    end
    tick();
    idle();
  endtask

  task automatic test_collision();
    do_reset();
    issue(5'd7);
    idle(); valid_d = 1; regwrite_d = 1; rd_d = 5'd7; regwrite_w = 1; rd_w = 5'd7;
    #1;
    n_chk++;
    if (obs !== 5'b00000) begin n_fail++; $display("FAIL collision_cycle: got %b want 00000", obs); end
    tick();
    idle(); valid_d = 1; uses_rs2_d = 1; rs2_d = 5'd7;
    #1;
    n_chk++;
    if (obs !== 5'b11010) begin n_fail++; $display("FAIL collision_busy_kept: got %b want 11010", obs); end
    idle();
    regwrite_w = 1; rd_w = 5'd7;
    tick();
    idle();
  endtask

  task automatic test_watchdog();
    int bad;
    do_reset();
    issue(5'd3);
    idle(); valid_d = 1; uses_rs1_d = 1; rs1_d = 5'd3;
    bad = 0;
    for (int c = 0; c < MAXS; c++) begin
      #1;
      if (obs !== 5'b11010) bad++;
      tick();
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL watchdog_stall_window: got %0d bad cycles want 0", bad); end
    #1;
    n_chk++;
    if (obs !== 5'b00001) begin n_fail++; $display("FAIL watchdog_recover: got %b want 00001", obs); end
    tick();
    for (int c = 0; c < 4; c++) begin
      #1;
      n_chk++;
      if (obs !== 5'b00001) begin n_fail++; $display("FAIL watchdog_sticky c%0d: got %b want 00001", c, obs); end
      tick();
    end
    n_chk++;
    if (stall_cnt !== 16'(MAXS)) begin n_fail++; $display("FAIL watchdog_stall_cnt: got %0d want %0d", stall_cnt, MAXS); end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    issue(5'd3);
    idle(); valid_d = 1; uses_rs1_d = 1; rs1_d = 5'd3;
    tick(); tick();
    #1;
    rst = 0;
    #1;
    n_chk++;
    if (obs !== 5'b00000 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_mid_stall: got ctrl=%b scnt=%0d want 00000 0", obs, stall_cnt);
    end
    tick();
    rst = 1;
    #1;
    n_chk++;
    if (obs !== 5'b00000) begin n_fail++; $display("FAIL reset_mid_stall_discard: got %b want 00000", obs); end
    tick();
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    issue(5'd3);
    idle(); valid_d = 1; uses_rs1_d = 1; rs1_d = 5'd3;
    repeat (19) tick();
    #1;
    n_chk++;
    if (s_stall_cnt !== 4'd15 || stall_cnt !== 16'd19) begin
      n_fail++; $display("FAIL sat_stall_cnt: got %0d/%0d want 15/19", s_stall_cnt, stall_cnt);
    end
    idle(); branch_taken_e = 1;
    repeat (19) tick();
    #1;
    n_chk++;
    if (s_flush_cnt !== 4'd15 || flush_cnt !== 16'd19) begin
      n_fail++; $display("FAIL sat_flush_cnt: got %0d/%0d want 15/19", s_flush_cnt, flush_cnt);
    end
    n_chk++;
    if (s_stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_stall_hold: got %0d want 15", s_stall_cnt); end
    idle();
  endtask

  task automatic test_random();
    int bad_ctrl, bad_cnt;
    do_reset();
    bad_ctrl = 0;
    bad_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      valid_d        = ($urandom_range(0, 3) != 0);
      uses_rs1_d     = $urandom_range(0, 1);
      uses_rs2_d     = $urandom_range(0, 1);
      regwrite_d     = ($urandom_range(0, 2) != 0);
      rs1_d          = 5'($urandom_range(0, 7));
      rs2_d          = 5'($urandom_range(0, 7));
      rd_d           = 5'($urandom_range(0, 7));
      regwrite_w     = ($urandom_range(0, 2) == 0);
      rd_w           = 5'($urandom_range(0, 7));
      branch_taken_e = ($urandom_range(0, 9) == 0);
      #1;
      if (obs !== m_ctrl()) begin
        bad_ctrl++;
        if (bad_ctrl < 4) $display("FAIL random_ctrl c%0d: got %b want %b", c, obs, m_ctrl());
      end
      if (stall_cnt !== m_scnt || flush_cnt !== m_fcnt || s_stall_cnt !== m_scnt_s || s_flush_cnt !== m_fcnt_s) begin
        bad_cnt++;
        if (bad_cnt < 4) $display("FAIL random_cnt c%0d: got %0d/%0d want %0d/%0d", c, stall_cnt, flush_cnt, m_scnt, m_fcnt);
      end
      tick();
    end
    n_chk++;
    if (bad_ctrl != 0) begin n_fail++; $display("FAIL random_ctrl_total: got %0d bad cycles want 0", bad_ctrl); end
    n_chk++;
    if (bad_cnt != 0) begin n_fail++; $display("FAIL random_cnt_total: got %0d bad cycles want 0", bad_cnt); end
    idle();
  endtask

  initial begin
    rst = 0;
    idle();
    m_clear();
    test_reset();
    test_raw_stall();
    test_branch_priority();
    test_collision();
    test_watchdog();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
